// File: rtl/pixel_pkg.sv
// -----------------------------------------------------------------------------
// pixel_pkg
// Shared definitions for the pixel packer:
//   - pack_state_e     : packer state (PACK while collecting pixels, FLUSH while
//                        draining a partial word)
//   - PACK_MODE_*      : encodings of the PACK_MODE parameter
//   - DEFAULT_*_WIDTH  : default pixel and FIFO word widths
//   - pixel_slot_bits  : buffer bits one accepted pixel occupies in a mode
// -----------------------------------------------------------------------------
package pixel_pkg;

    typedef enum logic {
        PACK  = 1'b0,
        FLUSH = 1'b1
    } pack_state_e;

    // One zero-extended pixel per FIFO word.
    localparam int PACK_MODE_WORD  = 0;
    // Dense LSB-first bitstream; pixels may straddle word boundaries.
    localparam int PACK_MODE_DENSE = 1;

    localparam int DEFAULT_PIXEL_WIDTH = 24;
    localparam int DEFAULT_WORD_WIDTH  = 32;

    // In word mode a pixel is widened to a full word before it enters the
    // buffer, so it consumes WORD_WIDTH bits of fill.
    function automatic int pixel_slot_bits(input int pack_mode,
                                           input int pixel_width,
                                           input int word_width);
        return (pack_mode == PACK_MODE_WORD) ? word_width : pixel_width;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk_i   : clock, rising edge
//   clr_i   : synchronous clear, wins over inc_i
//   inc_i   : add one on this edge unless already saturated
//   count_o : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/pixel_packer.sv
// -----------------------------------------------------------------------------
// pixel_packer
// Packs a stream of receiver pixels into FIFO words. In dense mode pixels are
// concatenated LSB-first into a continuous bitstream; in word mode every pixel
// gets its own zero-extended word. The source has no backpressure, so pixels
// that do not fit while the FIFO is full are dropped and counted.
//
// Ports
//   i_clock         : single clock, rising edge
//   i_reset         : synchronous active-high reset, highest priority
//   i_pixelData     : pixel from the receiver
//   i_pixelValid    : pixel qualifier, sampled every edge
//   i_flush         : pulse; emit any partial word, zero-padded
//   i_clearOverflow : clears the sticky overflow flag (not the drop count)
//   i_fifoFull      : FIFO full, asserted with at least one word of margin
//   o_fifoData      : packed word, holds its value between strobes
//   o_dataValid     : one-cycle write strobe for o_fifoData
//   o_overflow      : sticky, a pixel was dropped
//   o_dropCount     : saturating count of dropped pixels
//   o_busy          : buffer holds data or a flush is still pending
// -----------------------------------------------------------------------------
module pixel_packer
    import pixel_pkg::*;
#(
    parameter int PIXEL_WIDTH    = DEFAULT_PIXEL_WIDTH,
    parameter int WORD_WIDTH     = DEFAULT_WORD_WIDTH,
    parameter int PACK_MODE      = PACK_MODE_DENSE,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [PIXEL_WIDTH-1:0]    i_pixelData,
    input  logic                      i_pixelValid,
    input  logic                      i_flush,
    input  logic                      i_clearOverflow,
    input  logic                      i_fifoFull,
    output logic [WORD_WIDTH-1:0]     o_fifoData,
    output logic                      o_dataValid,
    output logic                      o_overflow,
    output logic [DROP_CNT_WIDTH-1:0] o_dropCount,
    output logic                      o_busy
);

    // The buffer holds one full word plus one pixel, so a pixel can always be
    // appended while a complete word waits for the FIFO.
    localparam int BUF_WIDTH  = WORD_WIDTH + PIXEL_WIDTH;
    localparam int FILL_WIDTH = $clog2(BUF_WIDTH + 1);
    localparam int FILL_EXT   = FILL_WIDTH + 1;
    localparam int SLOT_BITS  = pixel_slot_bits(PACK_MODE, PIXEL_WIDTH, WORD_WIDTH);

    localparam logic [FILL_WIDTH-1:0] WORD_FILL = FILL_WIDTH'(WORD_WIDTH);
    localparam logic [FILL_WIDTH-1:0] SLOT_FILL = FILL_WIDTH'(SLOT_BITS);
    localparam logic [FILL_EXT-1:0]   BUF_LIMIT = FILL_EXT'(BUF_WIDTH);

    // Mask keeping only the n valid low bits of an outgoing word; for n at or
    // above the word width the shift empties and the mask is all ones.
    function automatic logic [WORD_WIDTH-1:0] low_mask(input logic [FILL_WIDTH-1:0] n);
        return ~({WORD_WIDTH{1'b1}} << n);
    endfunction

    pack_state_e           state_q,    state_d;
    logic [BUF_WIDTH-1:0]  buf_q,      buf_d;
    logic [FILL_WIDTH-1:0] fill_q,     fill_d;
    logic [WORD_WIDTH-1:0] data_q,     data_d;
    logic                  valid_q,    valid_d;
    logic                  overflow_q, overflow_d;
    logic                  busy_q,     busy_d;

    logic                  word_ready;
    logic                  pop;
    logic                  accept;
    logic                  drop;
    logic [BUF_WIDTH-1:0]  buf_pop;
    logic [FILL_WIDTH-1:0] fill_pop;
    logic [FILL_EXT-1:0]   fill_need;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        buf_d      = buf_q;
        fill_d     = fill_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        overflow_d = overflow_q;
        busy_d     = 1'b0;
        buf_pop    = buf_q;
        fill_pop   = fill_q;
        accept     = 1'b0;
        drop       = 1'b0;
        fill_need  = '0;

        // Stage 1: pop a word if one is ready and the FIFO can take it.
        word_ready = (fill_q >= WORD_FILL) || ((state_q == FLUSH) && (fill_q != '0));
        pop        = word_ready && !i_fifoFull;

        if (pop) begin
            data_d   = buf_q[WORD_WIDTH-1:0] & low_mask(fill_q);
            valid_d  = 1'b1;
            buf_pop  = buf_q >> WORD_WIDTH;
            fill_pop = (fill_q >= WORD_FILL) ? (fill_q - WORD_FILL) : '0;
        end

        // Stage 2: append the incoming pixel at the post-pop fill level.
        // Pixels are only taken while packing; in FLUSH they are dropped so
        // the drained word cannot grow behind the flush.
        fill_need = {1'b0, fill_pop} + {1'b0, SLOT_FILL};
        accept    = i_pixelValid && (state_q == PACK) && (fill_need <= BUF_LIMIT);
        drop      = i_pixelValid && !accept;

        buf_d  = buf_pop;
        fill_d = fill_pop;
        if (accept) begin
            buf_d  = buf_pop | (BUF_WIDTH'(i_pixelData) << fill_pop);
            fill_d = fill_pop + SLOT_FILL;
        end

        // A drop on the same edge as a clear leaves the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (i_clearOverflow) begin
            overflow_d = 1'b0;
        end

        // A pixel arriving with the flush pulse was appended above, so it is
        // part of the flushed data. Nothing is appended in FLUSH, so the
        // post-pop fill level alone says whether draining is done.
        unique case (state_q)
            PACK:    if (i_flush)         state_d = FLUSH;
            FLUSH:   if (fill_pop == '0)  state_d = PACK;
            default:                      state_d = PACK;
        endcase

        busy_d = (fill_d != '0) || (state_d == FLUSH);
    end

    always_ff @(posedge i_clock) begin
        // NOTE: non-blocking assignments, so every register here samples the
        // values from before this edge regardless of statement order.
        if (i_reset) begin
            // NOTE: the buffer is a plain register and is cleared here on
            // purpose: packing ORs pixels in and relies on every bit above
            // the fill level being zero.
            state_q    <= PACK;
            buf_q      <= '0;
            fill_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    // Reset doubles as the counter clear so drops and reset share one edge.
    sat_counter #(
        .WIDTH (DROP_CNT_WIDTH)
    ) u_drop_cnt (
        .clk_i   (i_clock),
        .clr_i   (i_reset),
        .inc_i   (drop),
        .count_o (o_dropCount)
    );

    assign o_fifoData  = data_q;
    assign o_dataValid = valid_q;
    assign o_overflow  = overflow_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_pixel_packer.sv
// -----------------------------------------------------------------------------
// tb_pixel_packer
// Three packers share one stimulus: defaults, word mode, and a 4-bit drop
// counter. Expected words go into per-instance queues when the stimulus is
// driven and are compared when the instance strobes o_dataValid.
// -----------------------------------------------------------------------------
module tb_pixel_packer;
    import pixel_pkg::*;

    localparam int PW = 24;
    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] pix;
    logic          vld;
    logic          flush;
    logic          clr;
    logic          full;

    logic [WW-1:0] d_data, m_data, c_data;
    logic          d_dv,   m_dv,   c_dv;
    logic          d_ovf,  m_ovf,  c_ovf;
    logic          d_busy, m_busy, c_busy;
    logic [15:0]   d_cnt,  m_cnt;
    logic [3:0]    c_cnt;

    int checks   = 0;
    int failures = 0;

    logic [WW-1:0] sb_q[$];
    logic [WW-1:0] m0_q[$];
    bit            sb_en = 1'b0;
    bit            m0_en = 1'b0;

    always #5 clk = ~clk;

    pixel_packer u_dut (
        .i_clock(clk), .i_reset(rst), .i_pixelData(pix), .i_pixelValid(vld),
        .i_flush(flush), .i_clearOverflow(clr), .i_fifoFull(full),
        .o_fifoData(d_data), .o_dataValid(d_dv), .o_overflow(d_ovf),
        .o_dropCount(d_cnt), .o_busy(d_busy)
    );

    pixel_packer #(.PACK_MODE(PACK_MODE_WORD)) u_m0 (
        .i_clock(clk), .i_reset(rst), .i_pixelData(pix), .i_pixelValid(vld),
        .i_flush(flush), .i_clearOverflow(clr), .i_fifoFull(full),
        .o_fifoData(m_data), .o_dataValid(m_dv), .o_overflow(m_ovf),
        .o_dropCount(m_cnt), .o_busy(m_busy)
    );

    pixel_packer #(.DROP_CNT_WIDTH(4)) u_c4 (
        .i_clock(clk), .i_reset(rst), .i_pixelData(pix), .i_pixelValid(vld),
        .i_flush(flush), .i_clearOverflow(clr), .i_fifoFull(full),
        .o_fifoData(c_data), .o_dataValid(c_dv), .o_overflow(c_ovf),
        .o_dropCount(c_cnt), .o_busy(c_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors, sampling on the falling edge.
    always @(negedge clk) begin
        if (sb_en && d_dv) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dflt_word: got unexpected %08h, want no word", d_data);
            end else begin
                check("dflt_word", 64'(d_data), 64'(sb_q.pop_front()));
            end
        end
        if (m0_en && m_dv) begin
            if (m0_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL m0_word: got unexpected %08h, want no word", m_data);
            end else begin
                check("m0_word", 64'(m_data), 64'(m0_q.pop_front()));
            end
        end
    end

    typedef struct {
        logic          vld;
        logic [PW-1:0] pix;
        logic          flush;
        logic          push;
        logic [WW-1:0] word;
        logic          exp_dv;
        logic          exp_busy;
        logic [15:0]   exp_drops;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic v, input logic [PW-1:0] p, input logic f,
                                input logic ps, input logic [WW-1:0] w,
                                input logic dv, input logic b, input logic [15:0] dr);
        vec_t r;
        r.vld = v; r.pix = p; r.flush = f; r.push = ps; r.word = w;
        r.exp_dv = dv; r.exp_busy = b; r.exp_drops = dr;
        return r;
    endfunction

    // One clock: drive on the falling edge, return 1 ns after the rising edge.
    task automatic cyc(input logic v, input logic [PW-1:0] p, input logic f,
                       input logic fl, input logic c);
        @(negedge clk);
        rst = 1'b0; vld = v; pix = p; flush = f; full = fl; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; vld = 1'b0; pix = '0; flush = 1'b0; full = 1'b0; clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_row(input int i);
        if (tbl[i].push) sb_q.push_back(tbl[i].word);
        cyc(tbl[i].vld, tbl[i].pix, tbl[i].flush, 1'b0, 1'b0);
        check($sformatf("row%0d_dv", i),    64'(d_dv),   64'(tbl[i].exp_dv));
        check($sformatf("row%0d_busy", i),  64'(d_busy), 64'(tbl[i].exp_busy));
        check($sformatf("row%0d_drops", i), 64'(d_cnt),  64'(tbl[i].exp_drops));
        check($sformatf("row%0d_ovf", i),   64'(d_ovf),  64'(tbl[i].exp_drops != 16'd0));
    endtask

    // Idle until both scoreboards are empty, within a cycle budget.
    task automatic drain(input string name);
        int n = 0;
        while ((sb_q.size() != 0 || m0_q.size() != 0) && n < 20) begin
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check({name, "_pending"}, 64'(sb_q.size() + m0_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    logic          dv_seen;
    logic [127:0]  acc;
    int            nb;
    logic [PW-1:0] rp;

    initial begin
        rst = 1'b1; vld = 1'b0; pix = '0; flush = 1'b0; clr = 1'b0; full = 1'b0;

        //              vld   pix          flush push  word          dv    busy  drops
        tbl[0]  = mk(1'b1, 24'h000001, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 16'd0);
        tbl[1]  = mk(1'b1, 24'h000002, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 16'd0);
        tbl[2]  = mk(1'b1, 24'h000003, 1'b0, 1'b1, 32'h02000001, 1'b1, 1'b1, 16'd0);
        tbl[3]  = mk(1'b1, 24'h000004, 1'b0, 1'b1, 32'h00030000, 1'b1, 1'b1, 16'd0);
        tbl[4]  = mk(1'b0, 24'h000000, 1'b0, 1'b1, 32'h00000400, 1'b1, 1'b0, 16'd0);
        tbl[5]  = mk(1'b1, 24'hABCDEF, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 16'd0);
        tbl[6]  = mk(1'b0, 24'h000000, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1, 16'd0);
        tbl[7]  = mk(1'b0, 24'h000000, 1'b0, 1'b1, 32'h00ABCDEF, 1'b1, 1'b0, 16'd0);
        tbl[8]  = mk(1'b1, 24'h111111, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1, 16'd0);
        tbl[9]  = mk(1'b1, 24'h222222, 1'b0, 1'b1, 32'h00111111, 1'b1, 1'b0, 16'd1);
        tbl[10] = mk(1'b0, 24'h000000, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1, 16'd1);
        tbl[11] = mk(1'b0, 24'h000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 16'd1);
        tbl[12] = mk(1'b1, 24'h333333, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 16'd1);
        tbl[13] = mk(1'b0, 24'h000000, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1, 16'd1);
        tbl[14] = mk(1'b0, 24'h000000, 1'b1, 1'b1, 32'h00333333, 1'b1, 1'b0, 16'd1);

        // Reset state of all three instances.
        do_reset();
        do_reset();
        check("rst_data",   64'(d_data), 64'd0);
        check("rst_dv",     64'(d_dv),   64'd0);
        check("rst_ovf",    64'(d_ovf),  64'd0);
        check("rst_cnt",    64'(d_cnt),  64'd0);
        check("rst_busy",   64'(d_busy), 64'd0);
        check("rst_m0_all", 64'({m_data, m_dv, m_ovf, m_cnt, m_busy}), 64'd0);
        check("rst_c4_all", 64'({c_data, c_dv, c_ovf, c_cnt, c_busy}), 64'd0);

        // Packing, latency, flush, flush with pixel, drop in FLUSH.
        sb_en = 1'b1;
        for (int i = 0; i < 15; i++) apply_row(i);
        drain("table");

        // FIFO full with continuous pixels: two fit, the rest drop.
        do_reset();
        sb_q.push_back(32'h02000001);
        dv_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 24'(i + 1), 1'b0, 1'b1, 1'b0);
            if (d_dv) dv_seen = 1'b1;
        end
        check("full_dv_low", 64'(dv_seen), 64'd0);
        check("full_ovf",    64'(d_ovf),   64'd1);
        check("full_drops",  64'(d_cnt),   64'd98);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("release_dv",   64'(d_dv),   64'd1);
        check("release_data", 64'(d_data), 64'h02000001);
        sb_q.push_back(32'h00000000);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        drain("full");
        check("full_busy_end", 64'(d_busy), 64'd0);

        // Reset with 16 bits buffered and a sticky drop history.
        sb_q.push_back(32'h02000001);
        cyc(1'b1, 24'h000001, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 24'h000002, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        do_reset();
        check("midrst_dv",   64'(d_dv),   64'd0);
        check("midrst_data", 64'(d_data), 64'd0);
        check("midrst_ovf",  64'(d_ovf),  64'd0);
        check("midrst_cnt",  64'(d_cnt),  64'd0);
        check("midrst_busy", 64'(d_busy), 64'd0);
        for (int i = 0; i < 5; i++) apply_row(i);
        drain("midrst");

        // Word mode.
        do_reset();
        sb_en = 1'b0;
        m0_en = 1'b1;
        m0_q.push_back(32'h00FFFFFF);
        cyc(1'b1, 24'hFFFFFF, 1'b0, 1'b0, 1'b0);
        m0_q.push_back(32'h00123456);
        cyc(1'b1, 24'h123456, 1'b0, 1'b0, 1'b0);
        drain("m0");
        check("m0_drops", 64'(m_cnt),  64'd0);
        check("m0_ovf",   64'(m_ovf),  64'd0);
        check("m0_busy",  64'(m_busy), 64'd0);
        m0_en = 1'b0;

        // Saturating 4-bit counter and clear/drop collision.
        do_reset();
        for (int i = 0; i < 22; i++) cyc(1'b1, 24'(i), 1'b0, 1'b1, 1'b0);
        check("c4_sat",      64'(c_cnt), 64'd15);
        check("c4_ovf",      64'(c_ovf), 64'd1);
        check("dflt_cnt20",  64'(d_cnt), 64'd20);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("c4_clr_ovf",  64'(c_ovf), 64'd0);
        check("c4_clr_keep", 64'(c_cnt), 64'd15);
        cyc(1'b1, 24'h000055, 1'b0, 1'b1, 1'b1);
        check("c4_clr_drop_ovf", 64'(c_ovf), 64'd1);
        check("c4_clr_drop_cnt", 64'(c_cnt), 64'd15);
        check("dflt_cnt21",      64'(d_cnt), 64'd21);

        // Continuous random pixels with the FIFO never full: no drops.
        do_reset();
        sb_en = 1'b1;
        acc   = '0;
        nb    = 0;
        for (int i = 0; i < 40; i++) begin
            rp  = 24'($urandom);
            acc = acc | (128'(rp) << nb);
            nb  = nb + PW;
            if (nb >= WW) begin
                sb_q.push_back(acc[WW-1:0]);
                acc = acc >> WW;
                nb  = nb - WW;
            end
            cyc(1'b1, rp, 1'b0, 1'b0, 1'b0);
        end
        drain("stream");
        check("stream_drops", 64'(d_cnt),  64'd0);
        check("stream_ovf",   64'(d_ovf),  64'd0);
        check("stream_busy",  64'(d_busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_packer.md
PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 PIXEL_WIDTH, default 24, meaning: incoming pixel width in bits.
REQ-002 WORD_WIDTH, default 32, meaning: FIFO word width in bits; SHALL satisfy WORD_WIDTH >= PIXEL_WIDTH.
REQ-003 PACK_MODE, default 1, meaning: 1 = dense bitstream packing, 0 = one zero-extended pixel per word.
REQ-004 DROP_CNT_WIDTH, default 16, meaning: width of the saturating drop counter.
REQ-005 i_clock  in  1  single clock; all logic on rising edge.
REQ-006 i_reset  in  1  synchronous, active-high reset.
REQ-007 i_pixelData  in  PIXEL_WIDTH  pixel from the HDMI receiver.
REQ-008 i_pixelValid  in  1  pixel qualifier, sampled each edge; no backpressure to the source.
REQ-009 i_flush  in  1  single-cycle pulse: emit any partial word, zero-padded.
REQ-010 i_clearOverflow  in  1  clears o_overflow.
REQ-011 i_fifoFull  in  1  FIFO full flag; FIFO asserts it with at least one word of margin.
REQ-012 o_fifoData  out  WORD_WIDTH  packed word.
REQ-013 o_dataValid  out  1  one-cycle write strobe for o_fifoData.
REQ-014 o_overflow  out  1  sticky flag: a pixel was dropped.
REQ-015 o_dropCount  out  DROP_CNT_WIDTH  dropped pixel count, saturating.
REQ-016 o_busy  out  1  high while fill level > 0 or a flush is pending.

Function
REQ-017 Internal bit buffer SHALL be WORD_WIDTH+PIXEL_WIDTH bits with fill counter r_fill; packing is LSB-first, so each new pixel lands at bit position r_fill.
REQ-018 PACK_MODE=0 SHALL treat each accepted pixel as WORD_WIDTH bits, zero-extended.
REQ-019 A word SHALL be ready when r_fill >= WORD_WIDTH, or when in FLUSH with r_fill > 0.
REQ-020 When a word is ready and i_fifoFull is low at edge k, o_fifoData and o_dataValid SHALL be registered at edge k; the buffer shifts down by WORD_WIDTH and r_fill decreases by min(r_fill, WORD_WIDTH).
REQ-021 o_dataValid SHALL be low in every cycle that follows an edge at which i_fifoFull was high; o_fifoData holds its last value in those cycles.
REQ-022 Latency: if a pixel sampled at edge k completes a word, that word SHALL appear with o_dataValid high after edge k+1, provided the FIFO is not full.
REQ-023 A pixel SHALL be accepted when (r_fill after this edge's pop) + pixel size <= WORD_WIDTH+PIXEL_WIDTH; otherwise it is dropped.
REQ-024 When i_fifoFull stays low, no pixel SHALL ever be dropped, including when i_pixelValid is high on every cycle.
REQ-025 A drop SHALL set o_overflow and increment o_dropCount, which saturates at its maximum value.
REQ-026 i_clearOverflow SHALL clear o_overflow, but not o_dropCount; if a drop and i_clearOverflow occur on the same edge, o_overflow SHALL be 1.
REQ-027 State machine PACK/FLUSH:
- PACK -> FLUSH on i_flush.
- FLUSH -> PACK on the edge that emits the final partial word, or immediately if r_fill = 0.
REQ-028 If i_flush and i_pixelValid are high on the same edge, the pixel SHALL be absorbed first and then included in the flush.
REQ-029 Pixels arriving while in FLUSH SHALL be dropped and counted.
REQ-030 i_flush while already in FLUSH SHALL be ignored.
REQ-031 A flushed partial word SHALL zero all bits above r_fill.

Reset
REQ-032 i_reset SHALL clear, on the edge it is sampled: r_fill, buffer contents, o_fifoData, o_dataValid, o_overflow, o_dropCount and o_busy, and SHALL set the state to PACK.
REQ-033 Reset mid-operation SHALL discard any partial word without emitting it.
REQ-034 i_reset SHALL take priority over every other input.

Structure
REQ-035 A shared package pixel_pkg SHALL hold:
- the state enum (PACK, FLUSH);
- PACK_MODE encodings;
- the default PIXEL_WIDTH and WORD_WIDTH constants.
REQ-036 The saturating counter SHALL be a sub-module sat_counter, parametrised by width, with increment and clear inputs.

Verification
REQ-037 Defaults; pixels 0x000001, 0x000002, 0x000003, 0x000004 on consecutive cycles -> words 0x02000001, 0x00030000, 0x00000400, no drops.
REQ-038 Pixel 0xABCDEF, then i_flush -> a single word 0x00ABCDEF; state returns to PACK; o_busy = 0.
REQ-039 i_fifoFull held high with 100 continuous pixels -> o_dataValid stays 0, o_overflow = 1, o_dropCount = 98 (2 pixels fit in the buffer); after full deasserts, the buffered 32 bits are emitted first.
REQ-040 PACK_MODE=0; pixels 0xFFFFFF and 0x123456 -> words 0x00FFFFFF and 0x00123456.
REQ-041 i_reset asserted with r_fill = 16 -> no word emitted; all outputs 0 on the next cycle; the next 4 pixels pack exactly as in REQ-037.
REQ-042 DROP_CNT_WIDTH=4; 20 drops -> o_dropCount = 15; i_clearOverflow concurrent with a drop -> o_overflow = 1.
